// File: rtl/store_merge_queue.sv
// store_merge_queue
//   M-stage store queue. Places byte/half/word stores on their memory byte lanes and
//   buffers them in a DEPTH-entry FIFO. A store to the same word as the newest entry is
//   folded into that entry. Entries drain to data memory over a valid/ready port.
//   ld_hit flags a load whose word is still queued.
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   st_valid/st_ready          store handshake; st_addr/st_size/st_data describe the store
//   misalign_err               one-cycle pulse after an illegal store was accepted
//   mem_valid/mem_ready        drain handshake; mem_addr/mem_byteen/mem_wdata = head entry
//   ld_addr/ld_hit             load address in M stage / word is present in the queue
//   count                      number of occupied entries
module store_merge_queue #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 4,
    parameter int MERGE_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [1:0]                 st_size,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       misalign_err,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W/8-1:0]        mem_byteen,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int PW    = $clog2(DEPTH);
    localparam int WW    = ADDR_W - LB;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] TWO  = (PW+1)'(2);

    logic [WW-1:0]     word_q [DEPTH];
    logic [LANES-1:0]  be_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_last;
    logic [PW:0]   count_q, count_d;
    logic          mis_q, mis_d;

    logic [LB-1:0]     lane;
    int                nb;
    logic              legal;
    logic [LANES-1:0]  al_be;
    logic [DATA_W-1:0] al_data;
    logic [DATA_W-1:0] merge_data;
    logic              merge_ok, accept, do_push, do_merge, do_pop;
    logic [PW-1:0]     offs;

    // Lane alignment: byte k of the store lands on lane (lane + k).
    always_comb begin
        lane    = st_addr[LB-1:0];
        nb      = 1 << st_size;
        legal   = (nb <= LANES) && ((int'(lane) & (nb - 1)) == 0);
        al_be   = '0;
        al_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (legal && i >= int'(lane) && i < int'(lane) + nb) begin
                al_be[i]          = 1'b1;
                al_data[8*i +: 8] = st_data[8*(i - int'(lane)) +: 8];
            end
        end
    end

    // tail_q points at the next free slot; the newest entry sits one behind it.
    assign tail_last = tail_q - 1'b1;

    // Merging needs at least two entries so the head never changes under mem_valid.
    assign merge_ok = (MERGE_EN != 0) && (count_q >= TWO) && legal
                      && (st_addr[ADDR_W-1:LB] == word_q[tail_last]);
    assign st_ready = (count_q != FULL) || merge_ok;
    assign accept   = st_valid && st_ready;
    assign do_merge = accept && merge_ok;
    assign do_push  = accept && legal && !merge_ok;
    assign do_pop   = mem_valid && mem_ready;

    always_comb begin
        merge_data = data_q[tail_last];
        for (int i = 0; i < LANES; i++) begin
            if (al_be[i]) merge_data[8*i +: 8] = al_data[8*i +: 8];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mis_d   = accept && !legal;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            word_q[tail_q] <= st_addr[ADDR_W-1:LB];
            be_q[tail_q]   <= al_be;
            data_q[tail_q] <= al_data;
        end
        if (reset && do_merge) begin
            be_q[tail_last]   <= be_q[tail_last] | al_be;
            data_q[tail_last] <= merge_data;
        end
    end

    always_comb begin
        ld_hit = 1'b0;
        offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head_q;
            if (({1'b0, offs} < count_q) && (word_q[i] == ld_addr[ADDR_W-1:LB]))
                ld_hit = 1'b1;
        end
    end

    assign mem_valid    = (count_q != '0);
    assign mem_addr     = mem_valid ? {word_q[head_q], {LB{1'b0}}} : '0;
    assign mem_byteen   = mem_valid ? be_q[head_q] : '0;
    assign mem_wdata    = mem_valid ? data_q[head_q] : '0;
    assign misalign_err = mis_q;
    assign count        = count_q;
endmodule

// File: tb/tb_store_merge_queue.sv
// tb_store_merge_queue
//   Drives directed and random stores/drains into store_merge_queue and compares every
//   output each cycle against a queue-based model of the store queue behaviour.
module tb_store_merge_queue;
    localparam int DEPTH    = 4;
    localparam int MERGE_EN = 1;

    logic        clk = 1'b0;
    logic        reset, st_valid, st_ready, misalign_err, mem_valid, mem_ready, ld_hit;
    logic [31:0] st_addr, st_data, mem_addr, mem_wdata, ld_addr;
    logic [1:0]  st_size;
    logic [3:0]  mem_byteen;
    logic [2:0]  count;

    store_merge_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .MERGE_EN(MERGE_EN)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .misalign_err(misalign_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] word;
        logic [3:0]  be;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    logic exp_mis = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input logic mr, input logic [31:0] la,
                        input logic rst_n);
        int          lane, nb;
        logic        legal, mok, rdy, hit, acc, pop;
        logic [3:0]  be;
        logic [31:0] wd, lanemask;
        logic [63:0] dmask;
        ent_t        e;
        @(negedge clk);
        reset = rst_n; st_valid = v; st_addr = a; st_size = sz; st_data = d;
        mem_ready = mr; ld_addr = la;
        #1;
        lane  = int'(a[1:0]);
        nb    = 1 << sz;
        legal = (nb <= 4) && (lane % nb == 0);
        be    = legal ? 4'(((1 << nb) - 1) << lane) : 4'b0;
        dmask = (nb >= 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        wd    = legal ? 32'(({32'b0, d} & dmask) << (8 * lane)) : 32'b0;
        mok   = (MERGE_EN != 0) && (q.size() >= 2) && legal && (a[31:2] == q[q.size()-1].word);
        rdy   = (q.size() < DEPTH) || mok;
        hit   = 1'b0;
        foreach (q[i]) if (q[i].word == la[31:2]) hit = 1'b1;
        chk("count", 64'(count), 64'(q.size()));
        chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        chk("mem_addr", 64'(mem_addr), q.size() != 0 ? 64'({q[0].word, 2'b00}) : 64'd0);
        chk("mem_byteen", 64'(mem_byteen), q.size() != 0 ? 64'(q[0].be) : 64'd0);
        chk("mem_wdata", 64'(mem_wdata), q.size() != 0 ? 64'(q[0].data) : 64'd0);
        chk("st_ready", 64'(st_ready), 64'(rdy));
        chk("ld_hit", 64'(ld_hit), 64'(hit));
        chk("misalign_err", 64'(misalign_err), 64'(exp_mis));
        acc = v && rdy;
        pop = (q.size() != 0) && mr;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_mis = 1'b0;
        end else begin
            exp_mis = acc && !legal;
            if (acc && mok) begin
                lanemask = '0;
                for (int k = 0; k < 4; k++) if (be[k]) lanemask[8*k +: 8] = 8'hFF;
                q[q.size()-1].be   = q[q.size()-1].be | be;
                q[q.size()-1].data = (q[q.size()-1].data & ~lanemask) | (wd & lanemask);
            end
            if (pop) void'(q.pop_front());
            if (acc && legal && !mok) begin
                e.word = a[31:2]; e.be = be; e.data = wd;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic mr, input logic [31:0] la);
        step(1'b0, 32'h0, 2'd0, 32'h0, mr, la, 1'b1);
    endtask

    initial begin
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
        mem_ready = 1'b0; ld_addr = '0;
        step(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);

        // byte store on top lane
        step(1'b1, 32'h1003, 2'd0, 32'hFFFF_FFA5, 1'b0, 32'h0, 1'b1);
        #2;
        chk("byte_addr", 64'(mem_addr), 64'h1000);
        chk("byte_be", 64'(mem_byteen), 64'h8);
        chk("byte_data", 64'(mem_wdata), 64'hA500_0000);
        idle(1'b1, 32'h0);

        // misaligned half
        step(1'b1, 32'h2001, 2'd1, 32'h1234, 1'b1, 32'h0, 1'b1);
        #2;
        chk("mis_pulse", 64'(misalign_err), 64'd1);
        chk("mis_count", 64'(count), 64'd0);
        idle(1'b1, 32'h0);

        // merge of half + byte into the second entry
        step(1'b1, 32'h10, 2'd2, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h20, 2'd1, 32'hBEEF, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h22, 2'd0, 32'h07, 1'b0, 32'h0, 1'b1);
        #2;
        chk("merge_count", 64'(count), 64'd2);
        idle(1'b1, 32'h0);
        #2;
        chk("merge_addr", 64'(mem_addr), 64'h20);
        chk("merge_be", 64'(mem_byteen), 64'h7);
        chk("merge_data", 64'(mem_wdata), 64'h0007_BEEF);
        idle(1'b1, 32'h0);

        // full queue: new word refused, same-word merge accepted
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 2'd2, 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h200, 2'd2, 32'h5555_5555, 1'b0, 32'h0, 1'b1);
        #2;
        chk("full_count", 64'(count), 64'd4);
        step(1'b1, 32'h10D, 2'd0, 32'h5A, 1'b0, 32'h0, 1'b1);
        #2;
        chk("full_merge_count", 64'(count), 64'd4);
        step(1'b1, 32'h200, 2'd2, 32'h6666_6666, 1'b1, 32'h0, 1'b1);
        #2;
        chk("full_pop_count", 64'(count), 64'd3);
        step(1'b1, 32'h200, 2'd2, 32'h6666_6666, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1, 32'h0);

        // load hit
        step(1'b1, 32'h1000, 2'd2, 32'hABCD_0123, 1'b0, 32'h1002, 1'b1);
        idle(1'b0, 32'h1002);
        #2;
        chk("ld_hit_set", 64'(ld_hit), 64'd1);
        idle(1'b1, 32'h1002);
        #2;
        chk("ld_hit_clear", 64'(ld_hit), 64'd0);

        // reset while draining
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(4 * i), 2'd2, 32'(i), 1'b0, 32'h0, 1'b1);
        #2;
        chk("pre_reset_count", 64'(count), 64'd3);
        step(1'b0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b0);
        #2;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(mem_valid), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);

        // random traffic concentrated on a few words
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, la;
            a  = 32'h1000 + ($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 15));
            la = 32'h1000 + $urandom_range(0, 31);
            step($urandom_range(0, 9) < 7, a, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 1) == 1, la, $urandom_range(0, 199) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
